score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Consumes the per-frame 3-bit score pulse from the skeleton scorer stage.
//  Smooths it with a WINDOW-frame moving average and tracks the best average
//  over a timed round (ROUND_FRAMES scored frames). Then holds the result for
//  HOLD_FRAMES frames. Drives the score display / LED logic downstream.
// PARAMETERS
//  WINDOW        8    frames in moving average; power of 2, 2..32
//  ROUND_FRAMES  240  scored frames per round, >=1
//  HOLD_FRAMES   60   frames result is held after round end, >=1
//  PASS_SCORE    5    best average >= this asserts pass_out (0..7)
// PORTS
//  clk_in             in   1   system clock
//  rst_in             in   1   asynchronous, active-low reset
//  score_valid_in     in   1   1-cycle pulse, new frame score (scorer valid_out)
//  score_in           in   3   frame score 0..7, sampled when score_valid_in=1
//  start_in           in   1   1-cycle pulse, begin a round
//  avg_score_out      out  3   current moving average
//  best_score_out     out  3   max avg_score_out seen this round
//  round_active_out   out  1   high in RUN
//  round_done_out     out  1   1-cycle pulse at round end
//  pass_out           out  1   best_score_out>=PASS_SCORE, latched at round end
//  frames_left_out    out  FW  scored frames remaining in round; FW=$clog2(ROUND_FRAMES+1)
// BEHAVIOUR
//  - Reset (rst_in=0, async): state=IDLE.
//    All outputs 0; buffer, sum and counters 0.
//  - Buffer: WINDOW x 3-bit flop ring, write pointer wp ($clog2(WINDOW) bits, wraps).
//    Running sum SW = 3+$clog2(WINDOW) bits.
//  - Sample update: on a score_valid_in cycle in RUN:
//    sum <= sum + score_in - buf[wp]; buf[wp] <= score_in; wp <= wp+1.
//    avg_score_out <= (sum + score_in - buf[wp]) >> $clog2(WINDOW), registered.
//    Latency is 1 cycle after the pulse. No overflow: sum never exceeds 7*WINDOW.
//  - Fill: the buffer starts all-zero, so the average ramps up over the first
//    WINDOW frames. There is no divide-by-count.
//  - best_score_out <= max(best, new avg), updated in the same cycle as avg
//    (same 1-cycle latency).
//  - States:
//    - IDLE: outputs hold last round's avg/best/pass.
//      start_in -> RUN. On entry: clear buffer, sum, wp, avg, best, pass;
//      frames_left <= ROUND_FRAMES.
//    - RUN: round_active_out=1.
//      Each score_valid_in: perform the sample update; frames_left decrements.
//      When a pulse arrives with frames_left==1:
//        that sample is included; frames_left -> 0; round_done_out pulses next cycle;
//        pass_out <= (max(best,new avg) >= PASS_SCORE); state -> HOLD;
//        hold counter <= HOLD_FRAMES.
//      start_in during RUN is ignored.
//    - HOLD: avg/best/pass frozen. Each score_valid_in decrements the hold counter.
//      When the pulse arrives with the counter at 1 -> IDLE.
//      start_in in HOLD -> RUN immediately (same entry clearing as from IDLE).
//  - Simultaneous start_in and score_valid_in in IDLE/HOLD: start wins.
//    That score is discarded, not counted.
//  - score_valid_in outside RUN never changes buffer/sum/avg/best.
//  - Reset mid-round: async clear to the reset state. No round_done_out pulse.
//  - round_done_out is exactly one cycle wide. It never asserts outside the
//    RUN->HOLD transition.
// TESTING
//  - Reset: hold rst_in=0 with random inputs -> every output 0, state IDLE.
//    Release -> outputs stay 0.
//  - Ramp (WINDOW=8): start, then 8 pulses of score 7 -> avg 0,1,2,3,4,5,6,7.
//    Check each value 1 cycle after its pulse; best tracks avg.
//  - Wrap: after 8x7, feed 8x0 -> avg falls 6,5,..,0; best stays 7;
//    the ninth sample correctly evicts the first.
//  - Round end (ROUND_FRAMES=10, PASS_SCORE=5):
//    10 pulses of 7 -> round_done_out single pulse; pass_out=1; frames_left_out=0.
//    Repeat with all 2s -> pass_out=0.
//  - Hold/restart (HOLD_FRAMES=3):
//    after round end, 2 pulses -> still HOLD, outputs frozen; 3rd -> IDLE.
//    Separately, start_in in HOLD together with score_valid_in -> RUN,
//    buffer cleared, that score dropped, frames_left_out=ROUND_FRAMES.
//  - Ignore rules: start_in mid-RUN -> no effect.
//    Assert rst_in=0 mid-RUN -> immediate clear, no round_done_out.

Source files
------------

// File: rtl/score_tracker.sv
// Round-based score tracker: WINDOW-frame moving average of per-frame scores,
// best-average tracking over a timed round, then a hold period showing the result.
module score_tracker #(
  parameter int unsigned WINDOW       = 8,
  parameter int unsigned ROUND_FRAMES = 240,
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned PASS_SCORE   = 5,
  localparam int unsigned FW          = $clog2(ROUND_FRAMES + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          score_valid_in,
  input  logic [2:0]    score_in,
  input  logic          start_in,
  output logic [2:0]    avg_score_out,
  output logic [2:0]    best_score_out,
  output logic          round_active_out,
  output logic          round_done_out,
  output logic          pass_out,
  output logic [FW-1:0] frames_left_out
);

  localparam int unsigned WW = $clog2(WINDOW);
  localparam int unsigned SW = 3 + WW;
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [2:0]      win_q [WINDOW];
  logic [2:0]      win_d [WINDOW];
  logic [WW-1:0]   wp_q, wp_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [2:0]      avg_q, avg_d;
  logic [2:0]      best_q, best_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic [FW-1:0]   frames_q, frames_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [SW-1:0]   new_sum;
  logic [2:0]      new_avg;
  logic [2:0]      new_best;

  // Modular SW-bit arithmetic: the intermediate may wrap but the result never exceeds 7*WINDOW.
  always_comb begin
    new_sum  = sum_q + SW'(score_in) - SW'(win_q[wp_q]);
    new_avg  = 3'(new_sum >> WW);
    new_best = (new_avg > best_q) ? new_avg : best_q;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wp_d     = wp_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    best_d   = best_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    hold_d   = hold_q;

    unique case (state_q)
      StRun: begin
        if (score_valid_in) begin
          win_d[wp_q] = score_in;
          wp_d        = wp_q + 1'b1;
          sum_d       = new_sum;
          avg_d       = new_avg;
          best_d      = new_best;
          frames_d    = frames_q - 1'b1;
          if (frames_q == FW'(1)) begin
            pass_d  = (new_best >= 3'(PASS_SCORE));
            done_d  = 1'b1;
            hold_d  = HW'(HOLD_FRAMES);
            state_d = StHold;
          end
        end
      end
      StIdle, StHold: begin
        // Start beats a coincident score pulse; that score is dropped.
        if (start_in) begin
          for (int i = 0; i < WINDOW; i++) win_d[i] = 3'd0;
          wp_d     = '0;
          sum_d    = '0;
          avg_d    = 3'd0;
          best_d   = 3'd0;
          pass_d   = 1'b0;
          frames_d = FW'(ROUND_FRAMES);
          state_d  = StRun;
        end else if (state_q == StHold && score_valid_in) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= 3'd0;
      wp_q     <= '0;
      sum_q    <= '0;
      avg_q    <= 3'd0;
      best_q   <= 3'd0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wp_q     <= wp_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      best_q   <= best_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      frames_q <= frames_d;
      hold_q   <= hold_d;
    end
  end

  assign avg_score_out    = avg_q;
  assign best_score_out   = best_q;
  assign round_active_out = (state_q == StRun);
  assign round_done_out   = done_q;
  assign pass_out         = pass_q;
  assign frames_left_out  = frames_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a long-round instance for ramp/wrap and a
// 10-frame instance for round end, hold, restart and reset behaviour.
module tb_score_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       start;
  logic [2:0] score;

  logic [2:0] a_avg, a_best, b_avg, b_best;
  logic       a_act, a_done, a_pass, b_act, b_done, b_pass;
  logic [4:0] a_frames;
  logic [3:0] b_frames;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_tracker #(.WINDOW(8), .ROUND_FRAMES(20), .HOLD_FRAMES(3), .PASS_SCORE(5)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .score_valid_in(valid), .score_in(score), .start_in(start),
    .avg_score_out(a_avg), .best_score_out(a_best), .round_active_out(a_act),
    .round_done_out(a_done), .pass_out(a_pass), .frames_left_out(a_frames)
  );

  score_tracker #(.WINDOW(8), .ROUND_FRAMES(10), .HOLD_FRAMES(3), .PASS_SCORE(5)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .score_valid_in(valid), .score_in(score), .start_in(start),
    .avg_score_out(b_avg), .best_score_out(b_best), .round_active_out(b_act),
    .round_done_out(b_done), .pass_out(b_pass), .frames_left_out(b_frames)
  );

  task automatic pulse(input logic [2:0] s);
    @(negedge clk);
    valid = 1'b1;
    score = s;
    @(negedge clk);
    valid = 1'b0;
    score = 3'd0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid = 1'($urandom);
      start = 1'($urandom);
      score = 3'($urandom);
      #1;
      n_checks++;
      if ({a_avg, a_best, a_act, a_done, a_pass, a_frames,
           b_avg, b_best, b_act, b_done, b_pass, b_frames} !== 0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs a=%h/%h/%b%b%b/%0d b=%h/%h/%b%b%b/%0d, required all 0",
                 a_avg, a_best, a_act, a_done, a_pass, a_frames,
                 b_avg, b_best, b_act, b_done, b_pass, b_frames);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
    score = 3'd0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({a_avg, a_best, a_act, a_done, a_pass, a_frames,
           b_avg, b_best, b_act, b_done, b_pass, b_frames} !== 0) begin
        n_fail++;
        $display("FAIL reset_release: outputs not all 0 after release (a_act=%b b_act=%b)",
                 a_act, b_act);
      end
    end
  endtask

  task automatic test_ramp();
    do_start();
    n_checks++;
    if (a_act !== 1'b1 || a_frames !== 5'd20 || a_avg !== 3'd0) begin
      n_fail++;
      $display("FAIL ramp_start: act=%b frames=%0d avg=%0d, required 1/20/0", a_act, a_frames, a_avg);
    end
    for (int k = 1; k <= 8; k++) begin
      pulse(3'd7);
      n_checks++;
      if (a_avg !== 3'((7 * k) >> 3) || a_best !== 3'((7 * k) >> 3) || a_frames !== 5'(20 - k)) begin
        n_fail++;
        $display("FAIL ramp_%0d: avg=%0d best=%0d frames=%0d, required %0d/%0d/%0d", k, a_avg, a_best,
                 a_frames, (7 * k) >> 3, (7 * k) >> 3, 20 - k);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 1; k <= 8; k++) begin
      pulse(3'd0);
      n_checks++;
      if (a_avg !== 3'((56 - 7 * k) >> 3) || a_best !== 3'd7) begin
        n_fail++;
        $display("FAIL wrap_%0d: avg=%0d best=%0d, required %0d/7", k, a_avg, a_best,
                 (56 - 7 * k) >> 3);
      end
    end
  endtask

  task automatic test_round_end();
    do_start();
    n_checks++;
    if (b_act !== 1'b1 || b_frames !== 4'd10 || b_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL round_start: act=%b frames=%0d pass=%b, required 1/10/0", b_act, b_frames, b_pass);
    end
    for (int k = 1; k <= 9; k++) pulse(3'd7);
    n_checks++;
    if (b_done !== 1'b0 || b_frames !== 4'd1 || b_act !== 1'b1) begin
      n_fail++;
      $display("FAIL round_pre_end: done=%b frames=%0d act=%b, required 0/1/1", b_done, b_frames, b_act);
    end
    pulse(3'd7);
    n_checks++;
    if (b_done !== 1'b1 || b_pass !== 1'b1 || b_frames !== 4'd0 || b_act !== 1'b0 ||
        b_best !== 3'd7) begin
      n_fail++;
      $display("FAIL round_end: done=%b pass=%b frames=%0d act=%b best=%0d, required 1/1/0/0/7",
               b_done, b_pass, b_frames, b_act, b_best);
    end
    @(negedge clk);
    n_checks++;
    if (b_done !== 1'b0) begin
      n_fail++;
      $display("FAIL round_done_width: done=%b one cycle later, required 0", b_done);
    end
  endtask

  task automatic test_hold();
    for (int k = 1; k <= 3; k++) begin
      pulse(3'd3);
      n_checks++;
      if (b_avg !== 3'd7 || b_best !== 3'd7 || b_pass !== 1'b1 || b_act !== 1'b0 ||
          b_done !== 1'b0 || b_frames !== 4'd0) begin
        n_fail++;
        $display("FAIL hold_%0d: avg=%0d best=%0d pass=%b act=%b done=%b frames=%0d, required 7/7/1/0/0/0",
                 k, b_avg, b_best, b_pass, b_act, b_done, b_frames);
      end
    end
  endtask

  task automatic test_fail_round();
    do_start();
    n_checks++;
    if (b_pass !== 1'b0 || b_best !== 3'd0 || b_avg !== 3'd0 || b_frames !== 4'd10) begin
      n_fail++;
      $display("FAIL fail_start: pass=%b best=%0d avg=%0d frames=%0d, required 0/0/0/10",
               b_pass, b_best, b_avg, b_frames);
    end
    for (int k = 1; k <= 10; k++) begin
      pulse(3'd2);
      n_checks++;
      if (b_avg !== 3'((2 * k) >> 3)) begin
        n_fail++;
        $display("FAIL fail_avg_%0d: avg=%0d, required %0d", k, b_avg, (2 * k) >> 3);
      end
    end
    n_checks++;
    if (b_done !== 1'b1 || b_pass !== 1'b0 || b_best !== 3'd2) begin
      n_fail++;
      $display("FAIL fail_end: done=%b pass=%b best=%0d, required 1/0/2", b_done, b_pass, b_best);
    end
  endtask

  task automatic test_start_in_hold();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b1;
    score = 3'd7;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    score = 3'd0;
    n_checks++;
    if (b_act !== 1'b1 || b_frames !== 4'd10 || b_avg !== 3'd0 || b_best !== 3'd0) begin
      n_fail++;
      $display("FAIL restart: act=%b frames=%0d avg=%0d best=%0d, required 1/10/0/0",
               b_act, b_frames, b_avg, b_best);
    end
    for (int k = 1; k <= 7; k++) begin
      pulse(3'd7);
      n_checks++;
      if (b_avg !== 3'((7 * k) >> 3) || b_frames !== 4'(10 - k)) begin
        n_fail++;
        $display("FAIL restart_%0d: avg=%0d frames=%0d, required %0d/%0d", k, b_avg, b_frames,
                 (7 * k) >> 3, 10 - k);
      end
    end
  endtask

  task automatic test_ignore();
    do_start();
    n_checks++;
    if (b_act !== 1'b1 || b_frames !== 4'd3 || b_avg !== 3'd6 || b_best !== 3'd6) begin
      n_fail++;
      $display("FAIL start_in_run: act=%b frames=%0d avg=%0d best=%0d, required 1/3/6/6",
               b_act, b_frames, b_avg, b_best);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b_avg, b_best, b_act, b_done, b_pass, b_frames} !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_run: avg=%0d best=%0d act=%b done=%b pass=%b frames=%0d, required 0s",
               b_avg, b_best, b_act, b_done, b_pass, b_frames);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (b_done !== 1'b0 || b_act !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: done=%b act=%b, required 0/0", b_done, b_act);
      end
    end
    rst_n = 1'b1;
    pulse(3'd7);
    n_checks++;
    if (b_avg !== 3'd0 || b_frames !== 4'd0 || b_act !== 1'b0 || b_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: avg=%0d frames=%0d act=%b done=%b, required 0/0/0/0",
               b_avg, b_frames, b_act, b_done);
    end
  endtask

  initial begin
    valid = 1'b0;
    start = 1'b0;
    score = 3'd0;
    test_reset();
    test_ramp();
    test_wrap();
    test_round_end();
    test_hold();
    test_fail_round();
    test_start_in_hold();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
